// File: rtl/ssd_scan_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ssd_scan_sched                                              |
// | Purpose : 4-digit seven-segment refresh scheduler with per-frame      |
// |           snapshot, 16-step PWM brightness, leading-zero blanking.    |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module ssd_scan_sched #(
  parameter int SUB_DIV = 3125,
  parameter int SUB_W   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic       blank_en,
  input  logic [3:0] brightness,
  output logic [3:0] ssd,
  output logic [3:0] ssd_ctl,
  output logic [1:0] scan_idx,
  output logic       frame_done
);

  localparam logic [SUB_W-1:0] c_SUB_LAST = SUB_W'(SUB_DIV - 1);

  logic [SUB_W-1:0] r_sub;
  logic [3:0]       r_phase;
  logic [1:0]       r_idx;
  logic [3:0]       r_s0, r_s1, r_s2, r_s3, r_s_bri;
  logic             r_s_blank;
  logic             r_load_pending;
  logic             r_frame_flag;

  logic             w_sub_wrap;
  logic             w_phase_wrap;
  logic             w_at_t;
  logic [3:0]       w_digit;
  logic             w_blank0, w_blank1, w_blank2;
  logic             w_blanked;
  logic             w_lit;
  logic [3:0]       w_ctl;

  assign w_sub_wrap   = (r_sub == c_SUB_LAST);
  assign w_phase_wrap = w_sub_wrap && (r_phase == 4'd15);
  assign w_at_t       = w_phase_wrap && (r_idx == 2'd3);

  // Counters stay frozen on the post-reset load edge so slot 0 starts whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub          <= '0;
      r_phase        <= '0;
      r_idx          <= '0;
      r_s0           <= '0;
      r_s1           <= '0;
      r_s2           <= '0;
      r_s3           <= '0;
      r_s_bri        <= '0;
      r_s_blank      <= 1'b0;
      r_load_pending <= 1'b1;
      r_frame_flag   <= 1'b0;
    end else begin
      if (r_load_pending || w_at_t) begin
        r_s0      <= in0;
        r_s1      <= in1;
        r_s2      <= in2;
        r_s3      <= in3;
        r_s_bri   <= brightness;
        r_s_blank <= blank_en;
      end
      if (r_load_pending) begin
        r_load_pending <= 1'b0;
        r_frame_flag   <= 1'b0;
      end else begin
        r_sub        <= w_sub_wrap ? '0 : r_sub + SUB_W'(1);
        r_frame_flag <= w_at_t;
        if (w_sub_wrap)
          r_phase <= r_phase + 4'd1;
        if (w_phase_wrap)
          r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign w_blank0 = r_s_blank && (r_s0 == 4'd0);
  assign w_blank1 = w_blank0 && (r_s1 == 4'd0);
  assign w_blank2 = w_blank1 && (r_s2 == 4'd0);

  always_comb begin
    w_digit   = r_s0;
    w_blanked = 1'b0;
    case (r_idx)
      2'd0: begin w_digit = r_s0; w_blanked = w_blank0; end
      2'd1: begin w_digit = r_s1; w_blanked = w_blank1; end
      2'd2: begin w_digit = r_s2; w_blanked = w_blank2; end
      default: begin w_digit = r_s3; w_blanked = 1'b0; end
    endcase
  end

  assign w_lit = (r_phase <= r_s_bri) && !w_blanked;

  always_comb begin
    w_ctl = 4'b1111;
    if (w_lit) begin
      case (r_idx)
        2'd0:    w_ctl = 4'b0111;
        2'd1:    w_ctl = 4'b1011;
        2'd2:    w_ctl = 4'b1101;
        default: w_ctl = 4'b1110;
      endcase
    end
  end

  // Outputs hold reset values until the first snapshot has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssd        <= 4'd0;
      ssd_ctl    <= 4'b1111;
      scan_idx   <= 2'd0;
      frame_done <= 1'b0;
    end else if (r_load_pending) begin
      ssd        <= 4'd0;
      ssd_ctl    <= 4'b1111;
      scan_idx   <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      ssd        <= w_digit;
      ssd_ctl    <= w_ctl;
      scan_idx   <= r_idx;
      frame_done <= r_frame_flag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_sched.sv
`default_nettype none
// Scoreboard bench for ssd_scan_sched: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them and checks anode one-hotness.
module tb_ssd_scan_sched;

  localparam int SUB_DIV = 2;
  localparam int SUB_W   = 2;
  localparam int FRAME   = 64 * SUB_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in0 = 4'd1, in1 = 4'd2, in2 = 4'd3, in3 = 4'd4;
  logic       blank_en = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic [3:0] ssd;
  logic [3:0] ssd_ctl;
  logic [1:0] scan_idx;
  logic       frame_done;

  ssd_scan_sched #(.SUB_DIV(SUB_DIV), .SUB_W(SUB_W)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .blank_en(blank_en), .brightness(brightness),
    .ssd(ssd), .ssd_ctl(ssd_ctl), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] ctl;
    logic [3:0] ssd;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got ctl/ssd/idx/fd=%b required %b", name, cyc, act, req);
    end
  endtask

  task automatic push_one(input int c, input logic [3:0] ctl, input logic [3:0] d,
                          input logic [1:0] idx, input logic fd);
    exp_t e;
    e.cyc = c; e.ctl = ctl; e.ssd = d; e.idx = idx; e.fd = fd;
    q.push_back(e);
  endtask

  // Expand a hand-specified frame (digits, blanked-slot mask, brightness)
  // into per-cycle expectations starting at output cycle base.
  task automatic push_frame(input int base, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3,
                            input logic [3:0] mask, input int bri, input logic fd0,
                            input int nmax);
    logic [3:0] dig [4];
    logic [3:0] dec [4];
    dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
    dec[0] = 4'b0111; dec[1] = 4'b1011; dec[2] = 4'b1101; dec[3] = 4'b1110;
    for (int n = 0; n <= nmax; n++) begin
      int  s;
      int  i;
      logic lit;
      s   = (n / (16 * SUB_DIV)) % 4;
      i   = n % (16 * SUB_DIV);
      lit = !mask[s] && (i < (bri + 1) * SUB_DIV);
      push_one(base + n, lit ? dec[s] : 4'b1111, dig[s], 2'(s), (n == 0) ? fd0 : 1'b0);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare due expectations and the anode invariant every cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc)
        check("missed_slot", 11'h7ff, 11'h000);
      else
        check("scan", {ssd_ctl, ssd, scan_idx, frame_done}, {e.ctl, e.ssd, e.idx, e.fd});
    end
    if (!rst) begin
      logic ok;
      ok = (ssd_ctl == 4'b1111) ||
           (ssd_ctl == 4'b0111 && scan_idx == 2'd0) ||
           (ssd_ctl == 4'b1011 && scan_idx == 2'd1) ||
           (ssd_ctl == 4'b1101 && scan_idx == 2'd2) ||
           (ssd_ctl == 4'b1110 && scan_idx == 2'd3);
      check("anode_invariant", {10'd0, ok}, 11'd1);
    end
  end

  initial begin
    int c0;
    int c1;
    int f5;
    repeat (3) @(negedge clk);
    check("reset_values", {ssd_ctl, ssd, scan_idx, frame_done}, {4'b1111, 4'd0, 2'd0, 1'b0});

    // First frame after release, then PWM, blanking and snapshot frames.
    rst = 1'b0;
    c0  = cyc;
    push_one(c0 + 1, 4'b1111, 4'd0, 2'd0, 1'b0);
    push_frame(c0 + 2 + 0 * FRAME, 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 15, 1'b0, FRAME - 1);
    push_frame(c0 + 2 + 1 * FRAME, 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 3,  1'b1, FRAME - 1);
    push_frame(c0 + 2 + 2 * FRAME, 4'd0, 4'd0, 4'd5, 4'd0, 4'b0011, 3,  1'b1, FRAME - 1);
    push_frame(c0 + 2 + 3 * FRAME, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0111, 3,  1'b1, FRAME - 1);
    push_frame(c0 + 2 + 4 * FRAME, 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 15, 1'b1, FRAME - 1);
    f5 = c0 + 2 + 5 * FRAME;
    push_frame(f5, 4'd7, 4'd2, 4'd3, 4'd4, 4'b0000, 15, 1'b1, 70);

    wait_cyc(c0 + 2 + 0 * FRAME + 60);
    brightness = 4'd3;
    wait_cyc(c0 + 2 + 1 * FRAME + 60);
    in0 = 4'd0; in1 = 4'd0; in2 = 4'd5; in3 = 4'd0; blank_en = 1'b1;
    wait_cyc(c0 + 2 + 2 * FRAME + 60);
    in2 = 4'd0;
    wait_cyc(c0 + 2 + 3 * FRAME + 60);
    in0 = 4'd1; in1 = 4'd2; in2 = 4'd3; in3 = 4'd4; blank_en = 1'b0; brightness = 4'd15;
    wait_cyc(c0 + 2 + 4 * FRAME + 40);
    in0 = 4'd7;

    // Asynchronous reset in the middle of slot 2.
    wait_cyc(f5 + 70);
    #2 rst = 1'b1;
    #1 check("async_reset", {ssd_ctl, ssd, scan_idx, frame_done}, {4'b1111, 4'd0, 2'd0, 1'b0});
    repeat (3) @(negedge clk);
    in0 = 4'd1;
    rst = 1'b0;
    c1  = cyc;
    push_one(c1 + 1, 4'b1111, 4'd0, 2'd0, 1'b0);
    push_frame(c1 + 2, 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 15, 1'b0, FRAME - 1);
    push_frame(c1 + 2 + FRAME, 4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 15, 1'b1, 0);

    while (q.size() > 0 && cyc < c1 + 2 * FRAME + 20) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d expectations left, required 0", q.size());
      n_fail += q.size();
      n_vec  += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
